lmd_stage: RTL
==============

# lmd_stage

Parametrised load-memory-data pipeline register for the MEM→WB boundary. It captures the synchronous memory read word, extracts the addressed byte, half or word lane, and sign- or zero-extends it per load type. It presents the result to write-back with a valid bit. A one-entry hold buffer keeps a response that arrives during a stall, so the block does not depend on memory keeping its output stable while the pipeline is frozen.

## Interface
Parameters:
- DATA_W, 32: data path width. Legal values are 32 and 64 only.
- LANE_W, $clog2(DATA_W/8): width of the byte-offset field. Derived; do not override.
- HOLD_EN, 1: 1 enables the hold buffer. 0 gives a plain stall register, and a response arriving under stall is dropped.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- stall  in  1  freeze the WB output registers
- flush  in  1  kill the in-flight load; clears the output valid bit and the hold buffer
- rvalid  in  1  memory response valid this cycle
- rdata  in  DATA_W  raw memory word, aligned to DATA_W
- ld_type  in  3  RISC-V funct3, qualified by rvalid: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
- addr_lo  in  LANE_W  byte offset of the access, qualified by rvalid
- wb_valid  out  1  wb_data holds a completed load
- wb_data  out  DATA_W  extended load result
- wb_err  out  1  registered with wb_data; high when ld_type is unsupported
- held  out  1  hold buffer occupied
- ovf  out  1  one-cycle pulse; a response was dropped

## Operation
Extraction (combinational, applied to the selected source):
- Offset: addr_lo is masked to access alignment: lh uses addr_lo & ~1, lw uses addr_lo & ~3, ld uses 0.
- Lane: the lane at byte offset × 8 is taken from the word.
- Extension: lb, lh and lw (lw only when DATA_W=64) sign-extend to DATA_W. lbu, lhu and lwu zero-extend.
- lw at DATA_W=32 passes the word through.
- Unsupported codes: 011 and 110 at DATA_W=32, and 111 always. These give wb_data=0 and wb_err=1.

Source select: the hold entry if held=1, otherwise the live inputs (rdata, ld_type, addr_lo).

Per-cycle update, priority flush > stall > advance:
- flush=1:
  - wb_valid←0, wb_data←0, wb_err←0, hold cleared.
  - An rvalid in the same cycle is discarded. ovf stays 0, because this is an intentional kill.
- stall=1, flush=0:
  - wb_valid, wb_data and wb_err hold their values.
  - rvalid with held=0 and HOLD_EN=1: the hold buffer captures raw rdata, ld_type and addr_lo, and held←1.
  - rvalid with held=1, or rvalid with HOLD_EN=0: the response is dropped and ovf pulses.
- stall=0, flush=0, held=1:
  - wb_* load from the extracted hold entry, with wb_valid←1.
  - If rvalid is high the same cycle, the hold buffer refills with the new response and held stays 1. Otherwise held←0.
- stall=0, flush=0, held=0:
  - wb_valid←rvalid.
  - When rvalid=1, wb_data and wb_err load the extracted live input. When rvalid=0, wb_data and wb_err keep their old values.

Other rules:
- The hold buffer stores raw data. Extraction happens at drain time, not at capture.
- held is the registered occupancy flag; ovf is registered.

## Timing
- Reset (asynchronous assert, synchronous release at the clk edge):
  - wb_valid=0, wb_data=0, wb_err=0, held=0, ovf=0.
  - Hold entry contents become don't-care.
- Latency: rvalid at edge N gives wb_valid at edge N+1 when not stalled.
- Stalled response: a response arriving under stall reaches wb_* at the first edge where stall=0.
  - Example: stall high for cycles N..N+k, response at N. held=1 from N+1, and wb_valid=1 after edge N+k+1.
- Throughput: one response per cycle when unstalled. Only the drain-plus-refill case occupies the hold buffer across non-stalled cycles.
- Reset during stall: all state clears immediately, including a pending hold entry. No ovf is raised.
- flush and stall together: flush wins.

## Test plan
1. Sign and zero extension: DATA_W=32, rvalid, rdata=0x80F1_7F82, no stall.
   - lb at addr_lo=0 → 0xFFFF_FF82.
   - lbu at addr_lo=1 → 0x0000_007F.
   - lh at addr_lo=2 → 0xFFFF_80F1.
   - lhu at addr_lo=3 → 0x0000_80F1 (masked to offset 2).
   - lw → 0x80F1_7F82.
   - Each has wb_valid=1 one cycle later.
2. Stall capture: stall=1 for 3 cycles; lw of 0x1234_5678 arrives in the first stalled cycle, after which rdata becomes 0xDEAD_BEEF.
   - held=1 for the remainder of the stall.
   - wb_valid and wb_data unchanged during the stall.
   - After stall drops: wb_data=0x1234_5678, wb_valid=1, held=0.
3. Overflow: two rvalid cycles during a stall.
   - The second response is dropped with an ovf pulse.
   - After release, wb_data equals the first response.
   - With HOLD_EN=0, ovf pulses on the first response under stall.
4. Flush priority: held=1, then flush=1 with stall=1 and rvalid=1.
   - Next cycle: held=0, wb_valid=0, wb_data=0, ovf=0.
5. Illegal types: ld_type=111 → wb_err=1, wb_data=0. DATA_W=64 ld_type=011 with rdata=0x8000_0000_0000_0001 → passthrough. DATA_W=64 lw at addr_lo=4 with rdata[63:32]=0x8000_0000 → 0xFFFF_FFFF_8000_0000.
6. Asynchronous reset: drop resetn mid-clock while held=1 and wb_valid=1.
   - All outputs go to 0 before the next edge.
   - The first rvalid after release completes normally.

Source files
------------

// File: rtl/lmd_stage.sv
// lmd_stage: MEM->WB load-data pipeline register.
// Captures the synchronous memory read word, selects the addressed byte, half
// or word lane, and sign- or zero-extends it according to the load type. A
// one-entry hold buffer keeps a response that arrives while write-back is
// stalled, so memory need not hold its output stable across a stall.
module lmd_stage #(
    parameter int DATA_W  = 32,                  // 32 or 64 only
    parameter int LANE_W  = $clog2(DATA_W / 8),  // derived, do not override
    parameter bit HOLD_EN = 1'b1                 // 0: responses under stall are dropped
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall,
    input  logic              flush,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        ld_type,
    input  logic [LANE_W-1:0] addr_lo,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_err,
    output logic              held,
    output logic              ovf
);

    // RISC-V load funct3 encodings
    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LD  = 3'b011,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101,
        LD_LWU = 3'b110,
        LD_BAD = 3'b111
    } ld_type_e;

    // Raw (unextracted) hold entry; extraction happens when it drains
    logic [DATA_W-1:0] hold_data;
    logic [2:0]        hold_type;
    logic [LANE_W-1:0] hold_off;

    // Selected source for extraction
    logic [DATA_W-1:0] src_data;
    logic [2:0]        src_type;
    logic [LANE_W-1:0] src_off;

    // Extraction results
    logic [LANE_W-1:0] lane_off;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err;

    logic              hold_load;

    // Drain the hold entry ahead of the live response whenever it is occupied
    always_comb begin
        if (held) begin
            src_data = hold_data;
            src_type = hold_type;
            src_off  = hold_off;
        end else begin
            src_data = rdata;
            src_type = ld_type;
            src_off  = addr_lo;
        end
    end

    // Align the offset to the access size, shift the lane down and extend it
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statements can leave it unassigned (latch).
        lane_off = src_off;
        ext_data = '0;
        ext_err  = 1'b0;

        case (ld_type_e'(src_type))
            LD_LH, LD_LHU: lane_off[0]   = 1'b0;
            LD_LW, LD_LWU: lane_off[1:0] = 2'b00;
            LD_LD:         lane_off      = '0;
            default:       lane_off      = src_off;
        endcase

        lane = src_data >> {lane_off, 3'b000};

        case (ld_type_e'(src_type))
            LD_LB:  ext_data = DATA_W'($signed(lane[7:0]));
            LD_LH:  ext_data = DATA_W'($signed(lane[15:0]));
            LD_LBU: ext_data = DATA_W'(lane[7:0]);
            LD_LHU: ext_data = DATA_W'(lane[15:0]);
            LD_LW: begin
                // At 32 bits the word is the whole register: pass through
                if (DATA_W == 64) ext_data = DATA_W'($signed(lane[31:0]));
                else              ext_data = lane;
            end
            LD_LWU: begin
                if (DATA_W == 64) ext_data = DATA_W'(lane[31:0]);
                else              ext_err  = 1'b1;
            end
            LD_LD: begin
                if (DATA_W == 64) ext_data = lane;
                else              ext_err  = 1'b1;
            end
            default: ext_err = 1'b1;
        endcase
    end

    // The hold entry is written on capture under stall, or on refill while draining
    assign hold_load = HOLD_EN && rvalid && !flush && (stall ? !held : held);

    // Hold payload register
    // NOTE: the payload has no reset; `held` alone says whether it is
    // meaningful, so these flops are left out of the reset network.
    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_data <= rdata;
            hold_type <= ld_type;
            hold_off  <= addr_lo;
        end
    end

    // Write-back registers, occupancy flag and overflow pulse; flush > stall > advance
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_err   <= 1'b0;
            held     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (flush) begin
                // Intentional kill: same-cycle response discarded, no ovf
                wb_valid <= 1'b0;
                wb_data  <= '0;
                wb_err   <= 1'b0;
                held     <= 1'b0;
            end else if (stall) begin
                if (rvalid) begin
                    if (HOLD_EN && !held) held <= 1'b1;
                    else                  ovf  <= 1'b1;
                end
            end else if (held) begin
                wb_valid <= 1'b1;
                wb_data  <= ext_data;
                wb_err   <= ext_err;
                held     <= rvalid;   // refill keeps the entry occupied
            end else begin
                wb_valid <= rvalid;
                if (rvalid) begin
                    wb_data <= ext_data;
                    wb_err  <= ext_err;
                end
            end
        end
    end

endmodule
